ov7670_pixel_capture: RTL

OV7670_PIXEL_CAPTURE -- requirements
Module: ov7670_pixel_capture

---
 rtl/ov7670_pixel_capture.sv | 88 ++++++++
 1 files changed

// File: rtl/ov7670_pixel_capture.sv
// ov7670_pixel_capture: assembles OV7670 RGB565 byte pairs into frame-buffer writes
module ov7670_pixel_capture #(
   parameter int H_ACTIVE = 320,
   parameter int V_ACTIVE = 240
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_done,
   input  logic        vsync,
   input  logic        href,
   input  logic [7:0]  data,
   output logic        we,
   output logic [16:0] wAddr,
   output logic [15:0] wData,
   output logic        frame_done,
   output logic        overflow
);
   localparam int CW = $clog2(H_ACTIVE + 1);
   localparam int LW = $clog2(V_ACTIVE + 1);
   localparam logic [CW-1:0] H_C = CW'(H_ACTIVE);
   localparam logic [LW-1:0] V_L = LW'(V_ACTIVE);
   localparam logic [16:0]   H_A = 17'(H_ACTIVE);
   typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;
   state_t state, state_n;
   logic vsync_q, href_q, phase;
   logic [7:0] hi;
   logic [CW-1:0] col;
   logic [LW-1:0] line;
   logic vs_rise, vs_fall, active, in_range, wr, drop, fdone;
   // next state and per-cycle pixel decisions; cfg_done low overrides everything
   always_comb begin
      vs_rise  = vsync & ~vsync_q;
      vs_fall  = ~vsync & vsync_q;
      in_range = (col < H_C) && (line < V_L);
      active   = cfg_done && state == ACTIVE && !vs_rise;
      wr       = active && href && phase && in_range;
      drop     = active && href && phase && !in_range;
      fdone    = cfg_done && state == ACTIVE && vs_rise && line == V_L;
      state_n  = !cfg_done ? IDLE :
                 state == IDLE ? SYNC :
                 state == SYNC ? (vs_fall ? ACTIVE : SYNC) :
                 (vs_rise ? SYNC : ACTIVE);
   end
   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end
   // edge registers, byte pairing, line/column counters and registered write port
   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_q    <= 1'b0;
         href_q     <= 1'b0;
         phase      <= 1'b0;
         hi         <= '0;
         col        <= '0;
         line       <= '0;
         we         <= 1'b0;
         wAddr      <= '0;
         wData      <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         vsync_q    <= vsync;
         href_q     <= href;
         we         <= wr;
         frame_done <= fdone;
         if (drop) overflow <= 1'b1;
         if (wr) begin
            wAddr <= 17'(line) * H_A + 17'(col);
            wData <= {hi, data};
         end
         if (!active) begin
            col   <= '0;
            line  <= '0;
            phase <= 1'b0;
         end else if (href) begin
            phase <= ~phase;
            if (!phase) hi <= data;
            if (wr) col <= col + 1'b1;
         end else if (href_q) begin
            col   <= '0;
            phase <= 1'b0;
            if (line != V_L) line <= line + 1'b1;
         end
      end
   end
endmodule
